// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
// Sequential multiply (MUL_CYCLES busy cycles) and a restoring radix-2 divider
// (WIDTH+1 busy cycles) behind a start/busy/done handshake with flush.
// Optional feature macro: MULDIV_MADD_EN enables MADD/MADDU (op 110/111).
module muldiv_unit #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned MUL_CYCLES = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned W2      = 2 * WIDTH;
   localparam int unsigned CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [W2-1:0]    prod_q;
   logic             madd_q;
   logic [WIDTH-1:0] quot_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] dsr_q;
   logic [WIDTH-1:0] a_hold_q;
   logic             neg_q_q;
   logic             neg_r_q;
   logic             dz_q;

   logic             is_mul_c;
   logic             is_div_c;
   logic             op_signed_c;
   logic [W2-1:0]    a_ext_c;
   logic [W2-1:0]    b_ext_c;
   logic [W2-1:0]    prod_c;
   logic             a_neg_c;
   logic             b_neg_c;
   logic [WIDTH-1:0] a_mag_c;
   logic [WIDTH-1:0] b_mag_c;
   logic [WIDTH:0]   shift_c;
   logic [WIDTH:0]   diff_c;
   logic             q_bit_c;
   logic [WIDTH-1:0] q_fix_c;
   logic [WIDTH-1:0] r_fix_c;

   // Opcode decode, full-width product, operand magnitudes and one divide step
   always_comb begin
      is_mul_c    = (op[2:1] == 2'b00);
`ifdef MULDIV_MADD_EN
      is_mul_c    = is_mul_c | (op[2:1] == 2'b11);
`endif
      is_div_c    = (op[2:1] == 2'b01);
      op_signed_c = ~op[0];
      a_ext_c     = op_signed_c ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
      b_ext_c     = op_signed_c ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
      prod_c      = a_ext_c * b_ext_c;
      a_neg_c     = op_signed_c & a[WIDTH-1];
      b_neg_c     = op_signed_c & b[WIDTH-1];
      a_mag_c     = a_neg_c ? (~a + WIDTH'(1)) : a;
      b_mag_c     = b_neg_c ? (~b + WIDTH'(1)) : b;
      shift_c     = {rem_q, quot_q[WIDTH-1]};
      diff_c      = shift_c - {1'b0, dsr_q};
      q_bit_c     = ~diff_c[WIDTH];
      q_fix_c     = neg_q_q ? (~quot_q + WIDTH'(1)) : quot_q;
      r_fix_c     = neg_r_q ? (~rem_q + WIDTH'(1)) : rem_q;
   end

   // Control FSM, HI/LO update and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         prod_q      <= '0;
         madd_q      <= 1'b0;
         quot_q      <= '0;
         rem_q       <= '0;
         dsr_q       <= '0;
         a_hold_q    <= '0;
         neg_q_q     <= 1'b0;
         neg_r_q     <= 1'b0;
         dz_q        <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     if (is_mul_c) begin
                        prod_q <= prod_c;
                        madd_q <= op[2];
                        cnt    <= CW'(MUL_CYCLES - 1);
                        busy   <= 1'b1;
                        state  <= S_MUL;
                     end else if (is_div_c) begin
                        quot_q   <= a_mag_c;
                        rem_q    <= '0;
                        dsr_q    <= b_mag_c;
                        a_hold_q <= a;
                        neg_q_q  <= a_neg_c ^ b_neg_c;
                        neg_r_q  <= a_neg_c;
                        dz_q     <= (b == '0);
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= S_DIV;
                     end else if (op == 3'b100) begin
                        hi <= a;
                     end else if (op == 3'b101) begin
                        lo <= a;
                     end
                  end
               end
               S_MUL: begin
                  if (cnt == '0) begin
                     {hi, lo} <= madd_q ? ({hi, lo} + prod_q) : prod_q;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     state    <= S_IDLE;
                  end else begin
                     cnt <= cnt - CW'(1);
                  end
               end
               S_DIV: begin
                  if (cnt == CW'(WIDTH)) begin
                     lo          <= dz_q ? '1 : q_fix_c;
                     hi          <= dz_q ? a_hold_q : r_fix_c;
                     div_by_zero <= dz_q;
                     busy        <= 1'b0;
                     done        <= 1'b1;
                     cnt         <= '0;
                     state       <= S_IDLE;
                  end else begin
                     quot_q <= {quot_q[WIDTH-2:0], q_bit_c};
                     rem_q  <= q_bit_c ? diff_c[WIDTH-1:0] : shift_c[WIDTH-1:0];
                     cnt    <= cnt + CW'(1);
                  end
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit for the EX stage. It owns the HI/LO register pair.
- Runs alongside the combinational ALU and generalises the signed/unsigned arithmetic it does to WIDTH bits.
- Adds sequential multiply (configurable latency) and iterative divide, with a start/busy/done handshake and a pipeline flush input.
- The hazard unit stalls any MFHI/MFLO, or a new start, while busy=1.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be >= 4.
- MUL_CYCLES, 3, cycles busy is held for a multiply; must be >= 1.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MADDU.
- a  input  WIDTH  operand A / dividend / MTHI-MTLO source.
- b  input  WIDTH  operand B / divisor.
- flush  input  1  abort the in-flight operation (exception in a later stage).
- busy  output  1  an operation is in progress.
- done  output  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- div_by_zero  output  1  one-cycle pulse with done when a DIV/DIVU had b=0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high. Priority is reset > flush > start.
- Reset values: hi=0, lo=0, busy=0, done=0, div_by_zero=0, FSM=IDLE, counters=0.
- FSM states are IDLE, MUL and DIV.
  - Start is accepted in IDLE only (busy=0), including the cycle in which done=1.
  - Start while busy=1 is ignored.
- MTHI/MTLO: at the accepting edge, hi<=a (MTHI) or lo<=a (MTLO). No busy and no done.
- MULT/MULTU:
  - At the accepting edge, the full 2*WIDTH product of a and b is registered (signed for MULT, unsigned for MULTU), busy<=1 and the counter loads MUL_CYCLES-1.
  - Each MUL edge: if counter=0, {hi,lo}<=product, busy<=0, done<=1, FSM goes to IDLE. Otherwise the counter decrements.
  - Result: busy is high for exactly MUL_CYCLES cycles. done is high the cycle after busy falls.
- DIV/DIVU:
  - Restoring radix-2 divider, one quotient bit per cycle on magnitudes. Signs are latched at start.
  - WIDTH iteration cycles plus one sign-correction cycle: busy is high for WIDTH+1 cycles, then done pulses.
  - Signed: quotient truncates toward zero. Remainder takes the sign of the dividend.
  - Most-negative / -1 gives lo=most-negative, hi=0, with no flag.
  - b=0 (signed or unsigned): full latency is still used. Result lo={WIDTH{1}}, hi=a, and div_by_zero=1 together with done.
- Operands are captured at the accepting edge. Later changes on a, b and op have no effect on the running operation.
- flush=1:
  - In MUL/DIV: FSM goes to IDLE, busy<=0, and no done is generated. hi/lo are unchanged.
  - Coincident with a start: the start is ignored, including MTHI/MTLO.
  - On the edge where the operation would complete: flush wins, and hi/lo are not written.
- Reset mid-operation returns every register to its reset value on that edge.
- done and div_by_zero are each high for exactly one cycle per completed operation.
- Opcodes 110/111 are handled per the optional feature.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined:
  - op 110 MADD (signed) and op 111 MADDU (unsigned) behave like MULT/MULTU, with the same latency.
  - Final write is {hi,lo}<={hi,lo}+product, modulo 2^(2*WIDTH). The {hi,lo} value used is the one at the completing edge.
- Undefined: op 110/111 are ignored. No state change, busy stays 0, and no done is generated.

Test Plan:
1. WIDTH=32, MUL_CYCLES=3: MULT a=-3, b=5 -> busy high 3 cycles; then done=1 with hi=FFFFFFFF, lo=FFFFFFF1. MULTU a=FFFFFFFF, b=2 -> hi=00000001, lo=FFFFFFFE.
2. DIV a=-7, b=2 -> busy high 33 cycles; lo=FFFFFFFD, hi=FFFFFFFF. DIVU a=100, b=7 -> lo=0000000E, hi=00000002.
3. DIVU a=12345678, b=0 -> done and div_by_zero together after 33 busy cycles; lo=FFFFFFFF, hi=12345678. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0, div_by_zero=0.
4. Start DIV, assert flush on the 10th busy cycle -> busy=0 next cycle, no done, hi/lo keep prior values. Repeat with flush on the completing edge -> same response.
5. Handshake and priority:
   - MTHI a=AAAA5555, then MTLO a=1234 -> hi/lo update on the accept edge, with no busy and no done.
   - Start during busy -> ignored.
   - Start in the done cycle -> accepted.
   - reset during MUL -> all outputs 0 next cycle.
6. With MULDIV_MADD_EN: hi=0, lo=FFFFFFFF, then MADDU a=1, b=1 -> hi=00000001, lo=00000000. Without the macro: op 110 -> no busy, no done, hi/lo unchanged.
